// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell evaluated once per clock, LSB first,
// with a carry flop closing the loop between consecutive bit positions.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // state  | meaning
  // S_IDLE | waiting for start; operands captured on the accepting edge
  // S_RUN  | one bit per edge through the adder cell, WIDTH edges total
  // S_DONE | single-cycle done pulse, start ignored
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_last;

  assign w_fa_sum  = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_fa_cout = (r_opa[0] & r_opb[0]) | (r_carry & (r_opa[0] ^ r_opb[0]));
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_opa   <= a;
        r_opb   <= b;
        r_carry <= c_in;
        r_cnt   <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_acc   <= {w_fa_sum, r_acc[WIDTH-1:1]};
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_carry <= w_fa_cout;
      r_cnt   <= r_cnt + 1'b1;
      // Final bit goes straight to the result register alongside the shift.
      if (w_last) begin
        r_sum  <= {w_fa_sum, r_acc[WIDTH-1:1]};
        r_cout <= w_fa_cout;
      end
    end
  end

  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed cases, reset abort and
// randomized back-to-back operation against a + b + c_in.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int cyc      = 0;
  int prev_done_cyc = 0;
  bit have_prev = 0;
  bit b2b       = 0;
  logic [W:0] exp_q[$];
  logic [W:0] last_res;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return (W+1)'(t);
  endfunction

  // Monitor: compares on every done pulse, and checks result hold otherwise.
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst_n) begin
      last_res = {c_out, sum};
    end else begin
      if (done) begin
        done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_done got=%h required=no_done", {c_out, sum});
        end else begin
          e = exp_q.pop_front();
          if ({c_out, sum} !== e) begin
            failures++;
            $display("FAIL result got=%h required=%h", {c_out, sum}, e);
          end
        end
        if (b2b) begin
          if (have_prev) begin
            checks++;
            if (cyc - prev_done_cyc != W + 2) begin
              failures++;
              $display("FAIL done_spacing got=%0d required=%0d", cyc - prev_done_cyc, W + 2);
            end
          end
          have_prev = 1;
          prev_done_cyc = cyc;
        end
      end else begin
        checks++;
        if ({c_out, sum} !== last_res) begin
          failures++;
          $display("FAIL hold got=%h required=%h", {c_out, sum}, last_res);
        end
      end
      last_res = {c_out, sum};
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Called with the DUT in IDLE; returns with it back in IDLE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input bit poke_run, input bit poke_done);
    int d0, lat, busy_n;
    bit got;
    a = ta; b = tb_v; c_in = tc;
    exp_q.push_back(model(ta, tb_v, tc));
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_n = 0; got = 0;
    for (int k = 0; k < W + 6 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (done) begin
        got = 1;
        if (poke_done) start = 1'b1;
      end
      if (poke_run && k == 2) begin
        a = W'(8'h11); b = W'(8'h22); c_in = ~tc; start = 1'b1;
      end
      if (poke_run && k == 3) start = 1'b0;
    end
    check("done_seen", int'(got), 1);
    check("latency", lat - 1, W);
    check("busy_cycles", busy_n, W);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("reset_idle", int'({busy, done, c_out, sum}), 0);
    end

    run_op(8'h3C, 8'h42, 1'b0, 0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 0);
    run_op(8'hA5, 8'h5A, 1'b1, 0, 0);
    run_op(8'h00, 8'h00, 1'b1, 0, 0);
    run_op(8'h12, 8'h34, 1'b1, 1, 0);
    run_op(W'($urandom), W'($urandom), 1'($urandom), 0, 1);

    // Reset during RUN: aborted result never appears.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; c_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    check("abort_outputs", int'({busy, done, c_out, sum}), 0);
    repeat (W + 4) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_op(8'h80, 8'h80, 1'b0, 0, 0);

    // Back-to-back with start held high.
    @(negedge clk);
    b2b = 1; have_prev = 0;
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      exp_q.push_back(model(a, b, c_in));
      @(posedge clk); #1;
      if (i == 999) start = 1'b0;
      else begin
        repeat (W + 1) @(posedge clk);
        #1;
      end
    end
    for (int k = 0; k < 4 * W && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    repeat (W + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
